// File: rtl/l1_pkg.sv
// Shared definitions for the layer1 stream reader.
// Holds the layer1 geometry, data/address widths, the {9,4} pixel type and
// the reader FSM state encoding.
package l1_pkg;

   localparam int unsigned IMG_W       = 32;
   localparam int unsigned IMG_H       = 32;
   localparam int unsigned DW          = 13;
   localparam int unsigned AW          = 13;
   localparam int unsigned LAYER1_BASE = 0;
   localparam int unsigned FIFO_DEPTH  = 2;

   // Unsigned {9,4} fixed point: 9 integer bits, 4 fraction bits (post-ReLU)
   typedef logic [DW-1:0] fix94_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO used as the read-data skid buffer.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   push, din   : write strobe and data
//   pop, dout   : read strobe and head-of-queue data (show-ahead)
//   count       : current occupancy (0..DEPTH)
//   full, empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 13
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   // Storage and pointers; storage is cleared so the head reads 0 after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         if (pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign count = r_count;
   assign full  = (r_count == CW'(DEPTH));
   assign empty = (r_count == CW'(0));

   a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/l1_stream_reader.sv
// Reads the finished layer1 map in raster order and streams it out as a
// valid/ready stream while accumulating frame max and sum.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start               : one-cycle pulse, starts a frame when idle
//   busy, done          : frame in progress / one-cycle end-of-frame pulse
//   crd, caddr_rd       : registered memory read enable and address
//   cdata_rd            : read data, valid the cycle after crd
//   csel                : memory select, 1 (layer1) while busy
//   out_valid/ready     : stream handshake
//   out_data, out_last  : pixel value, final-beat marker
//   max_val, sum_val    : frame statistics, valid when done
module l1_stream_reader #(
   parameter int unsigned IMG_W      = l1_pkg::IMG_W,
   parameter int unsigned IMG_H      = l1_pkg::IMG_H,
   parameter int unsigned DW         = l1_pkg::DW,
   parameter int unsigned AW         = l1_pkg::AW,
   parameter int unsigned BASE_ADDR  = l1_pkg::LAYER1_BASE,
   parameter int unsigned FIFO_DEPTH = l1_pkg::FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              crd,
   output logic [AW-1:0]     caddr_rd,
   input  logic [DW-1:0]     cdata_rd,
   output logic              csel,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW-1:0]     out_data,
   output logic              out_last,
   output logic [DW-1:0]     max_val,
   output logic [DW+9:0]     sum_val
);

   import l1_pkg::*;

   localparam int unsigned NPIX = IMG_W * IMG_H;
   localparam int unsigned IW   = $clog2(NPIX + 1);
   localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned OW   = CW + 1;
   localparam int unsigned SW   = DW + 10;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_crd;
   logic              r_push;
   logic [AW-1:0]     r_caddr;
   logic [IW-1:0]     r_rd_idx;
   logic [IW-1:0]     r_pop_idx;
   logic [DW-1:0]     r_max;
   logic [SW-1:0]     r_sum;

   logic [CW-1:0]     w_count;
   logic              w_full;
   logic              w_empty;
   logic              w_pop;
   logic              w_start_ok;
   logic [IW-1:0]     w_idx;
   logic [OW-1:0]     w_occ;
   logic              w_issue;
   logic              w_drained;

   // Skid buffer: read data lands here the cycle after crd
   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DW)
   ) u_fifo (
      .clk   (clk),
      .rst   (reset),
      .push  (r_push),
      .pop   (w_pop),
      .din   (cdata_rd),
      .dout  (out_data),
      .count (w_count),
      .full  (w_full),
      .empty (w_empty)
   );

   assign out_valid  = !w_empty;
   assign out_last   = !w_empty && (r_pop_idx == IW'(NPIX - 1));
   assign w_pop      = !w_empty && out_ready;
   assign w_start_ok = (r_state == ST_IDLE) && start;

   // The first read is issued on the edge that accepts start
   assign w_idx = w_start_ok ? IW'(0) : r_rd_idx;

   // Slots already claimed after this edge: buffered + pushing now + issued
   // last cycle, less the beat leaving now. A new read may only take a free one.
   assign w_occ = OW'(w_count) + OW'(r_push) + OW'(r_crd) - OW'(w_pop);

   assign w_issue = (w_start_ok || (r_state == ST_READ))
                    && (w_idx < IW'(NPIX))
                    && (w_occ < OW'(FIFO_DEPTH));

   // Nothing left after this edge: lets done follow the last beat by one cycle
   assign w_drained = !r_crd && !r_push
                      && ((w_count == CW'(0)) || ((w_count == CW'(1)) && w_pop));

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (start) w_state_nxt = ST_READ;
         end
         ST_READ: begin
            if ((r_rd_idx == IW'(NPIX)) || (w_issue && (r_rd_idx == IW'(NPIX - 1))))
               w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_drained) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Output decode from the state register
   always_comb begin
      busy = 1'b0;
      csel = 1'b0;
      done = 1'b0;
      unique case (r_state)
         ST_READ, ST_DRAIN: begin
            busy = 1'b1;
            csel = 1'b1;
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // Read issue, address counter and statistics
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_crd     <= 1'b0;
         r_push    <= 1'b0;
         r_caddr   <= '0;
         r_rd_idx  <= '0;
         r_pop_idx <= '0;
         r_max     <= '0;
         r_sum     <= '0;
      end else begin
         r_crd  <= w_issue;
         r_push <= r_crd;
         if (w_issue) begin
            r_caddr  <= AW'(BASE_ADDR) + AW'(w_idx);
            r_rd_idx <= w_idx + IW'(1);
         end else if (w_start_ok) begin
            r_rd_idx <= '0;
         end
         if (w_start_ok) begin
            r_pop_idx <= '0;
            r_max     <= '0;
            r_sum     <= '0;
         end else if (w_pop) begin
            r_pop_idx <= r_pop_idx + IW'(1);
            r_sum     <= r_sum + SW'(out_data);
            if (out_data > r_max) r_max <= out_data;
         end
      end
   end

   assign crd      = r_crd;
   assign caddr_rd = r_caddr;
   assign max_val  = r_max;
   assign sum_val  = r_sum;

   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
                                   !(r_push && w_full && !w_pop));

endmodule

// File: tb/tb_l1_stream_reader.sv
// Self-checking bench for l1_stream_reader: table of frame scenarios plus
// hand-written reset-at-power-up and reset-mid-frame sequences.
module tb_l1_stream_reader;
   import l1_pkg::*;

   localparam int unsigned NPIX = IMG_W * IMG_H;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              out_ready = 1'b0;
   logic              busy, done, crd, csel, out_valid, out_last;
   logic [AW-1:0]     caddr_rd;
   logic [DW-1:0]     cdata_rd = '0;
   logic [DW-1:0]     out_data, max_val;
   logic [DW+9:0]     sum_val;

   fix94_t            mem [2**AW];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc   = 0;   // beats accepted in current frame
   int issued = 0;  // reads issued in current frame
   int lasts = 0;
   int dones = 0;
   int g_start_reqs = 0;
   int g_test_id    = 0;
   int g_ready_mode = 0;   // 0: always ready, 1: toggle, 2: 20-cycle stall at beat 100
   int g_restart_at = -1;

   typedef struct {
      bit          ones;
      int          rmode;
      int          restart;
      logic [31:0] exp_max;
      logic [31:0] exp_sum;
   } vec_t;

   l1_stream_reader dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .crd       (crd),
      .caddr_rd  (caddr_rd),
      .cdata_rd  (cdata_rd),
      .csel      (csel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .max_val   (max_val),
      .sum_val   (sum_val)
   );

   always #5 clk = ~clk;

   // Memory model: data valid the cycle after crd
   always @(posedge clk) cdata_rd <= crd ? mem[caddr_rd] : '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor_loop();
      logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
      logic [DW-1:0] pd = '0;
      int  last_cyc = -10;
      int  s_cyc = 0;
      bit  waiting_valid = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            pv = 1'b0;
            pr = 1'b0;
            waiting_valid = 1'b0;
            continue;
         end
         chk("csel_eq_busy", 32'(csel), 32'(busy));
         if (start && !busy && !done) begin
            acc = 0; issued = 0; lasts = 0;
            s_cyc = cyc; waiting_valid = 1'b1;
         end
         if (waiting_valid && out_valid) begin
            chk("first_valid_latency", 32'(cyc - s_cyc), 32'd3);
            waiting_valid = 1'b0;
         end
         if (crd) begin
            chk("rd_addr", 32'(caddr_rd), 32'(LAYER1_BASE + issued));
            issued++;
         end
         if (busy) chk("outstanding_le_depth", 32'(issued - acc <= int'(FIFO_DEPTH)), 32'd1);
         if (pv && !pr) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(pd));
            chk("hold_last", 32'(out_last), 32'(pl));
         end
         if (g_ready_mode == 2 && out_ready && !pr && acc == 100) begin
            chk("resume_valid", 32'(out_valid), 32'd1);
            chk("resume_data", 32'(out_data), 32'd100);
            chk("reads_past_99", 32'(issued <= 102), 32'd1);
         end
         if (out_valid && out_ready) begin
            chk("beat_data", 32'(out_data), 32'(mem[AW'(LAYER1_BASE + acc)]));
            chk("beat_last", 32'(out_last), 32'(acc == int'(NPIX) - 1));
            if (out_last) lasts++;
            if (acc == int'(NPIX) - 1) last_cyc = cyc;
            acc++;
         end
         if (done) begin
            dones++;
            chk("done_after_last", 32'(cyc - last_cyc), 32'd1);
         end
         pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      end
   endtask

   task automatic driver_loop();
      int  seen_reqs = 0;
      int  stall_cnt = 0;
      int  my_test = -1;
      bit  restarted = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (my_test != g_test_id) begin
            my_test = g_test_id; stall_cnt = 0; restarted = 1'b0;
         end
         start = 1'b0;
         if (seen_reqs != g_start_reqs) begin
            start = 1'b1;
            seen_reqs++;
         end else if (g_restart_at >= 0 && !restarted && acc == g_restart_at && busy) begin
            start = 1'b1;
            restarted = 1'b1;
         end
         case (g_ready_mode)
            1: out_ready = !out_ready;
            2: begin
               if (acc == 100 && stall_cnt < 20) begin
                  out_ready = 1'b0;
                  stall_cnt++;
               end else begin
                  out_ready = 1'b1;
               end
            end
            default: out_ready = 1'b1;
         endcase
      end
   endtask

   task automatic fill_mem(input bit ones);
      for (int a = 0; a < 2**AW; a++) begin
         mem[a] = ones ? 13'h1FFF : ((a < int'(NPIX)) ? DW'(a) : '0);
      end
   endtask

   task automatic run_row(input vec_t v);
      int d0;
      int to;
      fill_mem(v.ones);
      g_ready_mode = v.rmode;
      g_restart_at = v.restart;
      g_test_id++;
      d0 = dones;
      g_start_reqs++;
      to = 0;
      while (dones == d0 && to < 8000) begin
         @(posedge clk);
         to++;
      end
      repeat (5) @(posedge clk);
      #2;
      chk("done_pulses", 32'(dones - d0), 32'd1);
      chk("beat_count", 32'(acc), 32'(NPIX));
      chk("last_count", 32'(lasts), 32'd1);
      chk("max_val", 32'(max_val), v.exp_max);
      chk("sum_val", 32'(sum_val), v.exp_sum);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_crd", 32'(crd), 32'd0);
   endtask

   vec_t vt [5];

   initial begin
      int d0;
      int to;
      fork
         monitor_loop();
         driver_loop();
      join_none

      fill_mem(1'b0);
      repeat (3) @(posedge clk);
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_crd", 32'(crd), 32'd0);
      chk("rst_caddr", 32'(caddr_rd), 32'd0);
      chk("rst_csel", 32'(csel), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_max", 32'(max_val), 32'd0);
      chk("rst_sum", 32'(sum_val), 32'd0);
      reset = 1'b0;

      // ramp data k at address k: max 1023, sum 1023*1024/2 = 523776
      vt[0] = '{ones: 1'b0, rmode: 0, restart: -1, exp_max: 32'd1023, exp_sum: 32'd523776};
      vt[1] = '{ones: 1'b0, rmode: 1, restart: -1, exp_max: 32'd1023, exp_sum: 32'd523776};
      vt[2] = '{ones: 1'b0, rmode: 2, restart: -1, exp_max: 32'd1023, exp_sum: 32'd523776};
      // saturated data: 8191 * 1024 = 8387584
      vt[3] = '{ones: 1'b1, rmode: 0, restart: -1, exp_max: 32'd8191, exp_sum: 32'd8387584};
      vt[4] = '{ones: 1'b0, rmode: 0, restart: 10, exp_max: 32'd1023, exp_sum: 32'd523776};
      for (int i = 0; i < 5; i++) run_row(vt[i]);

      // reset asserted mid-frame at beat 500
      fill_mem(1'b1);
      g_ready_mode = 0;
      g_restart_at = -1;
      g_test_id++;
      d0 = dones;
      g_start_reqs++;
      to = 0;
      while (!busy && to < 100) begin
         @(posedge clk);
         to++;
      end
      while (acc < 500 && to < 8000) begin
         @(posedge clk);
         to++;
      end
      chk("reached_beat_500", 32'(acc >= 500), 32'd1);
      #2;
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_crd", 32'(crd), 32'd0);
      chk("midrst_caddr", 32'(caddr_rd), 32'd0);
      chk("midrst_csel", 32'(csel), 32'd0);
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_data", 32'(out_data), 32'd0);
      chk("midrst_last", 32'(out_last), 32'd0);
      chk("midrst_max", 32'(max_val), 32'd0);
      chk("midrst_sum", 32'(sum_val), 32'd0);
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      repeat (5) @(posedge clk);
      chk("midrst_no_done", 32'(dones - d0), 32'd0);
      run_row(vt[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
